wb_trace_fifo: RTL and testbench
================================

// Module: wb_trace_fifo
// PURPOSE
//  Commit-trace buffer downstream of the pipeline's writeback debug port.
//  Captures each register-file write retired in WB (pc, rf addr, data) and tags it with a sequence number.
//  Queues entries in a first-word-fall-through FIFO and drains them over a valid/ready handshake
//  to a trace consumer (UART dumper or golden-model comparator).
//  Counts entries dropped when the consumer cannot keep up.
// PARAMETERS
//  DEPTH   16  FIFO entries; power of 2, >=2
//  SEQ_W   16  sequence-number width; wraps modulo 2^SEQ_W
//  DROP_W  16  drop-counter width; saturates at all-ones
// PORTS
//  clk              in   1       clock, single domain
//  reset            in   1       synchronous, active-high
//  trace_en         in   1       1 = capture enabled; 0 = ignore WB commits, drain continues
//  clr_ovf          in   1       1-cycle pulse; clears ovf_sticky and drop_cnt
//  debug_wb_pc      in   32      PC of instruction in WB
//  debug_wb_rf_wen  in   1       RF write enable in WB
//  debug_wb_rf_addr in   5       RF write address in WB
//  debug_wb_rf_wdata in  32      RF write data in WB
//  trace_valid      out  1       head entry available
//  trace_ready      in   1       consumer accepts head entry this cycle
//  trace_pc         out  32      head entry PC
//  trace_addr       out  5       head entry RF address
//  trace_wdata      out  32      head entry write data
//  trace_seq        out  SEQ_W   head entry sequence number
//  fifo_count       out  log2(DEPTH)+1  entries held
//  ovf_sticky       out  1       set on first drop; held until clr_ovf or reset
//  drop_cnt         out  DROP_W  commits dropped because FIFO was full
// BEHAVIOUR
//  - Reset, synchronous on posedge clk: FIFO empty, ptrs=0, seq=0, fifo_count=0, trace_valid=0,
//    ovf_sticky=0, drop_cnt=0. trace_pc/addr/wdata/seq=0 while empty.
//  - Reset mid-stream discards all queued entries. No output handshake completes in the reset cycle.
//  - Commit condition: cap = trace_en & debug_wb_rf_wen & (debug_wb_rf_addr != 0).
//  - Writes to $0 are never traced and do not consume a sequence number.
//  - pop = trace_valid & trace_ready.
//  - push = cap & (fifo_count < DEPTH | pop). A full FIFO accepts a push in the same cycle as a pop.
//  - Latency: a captured commit at edge N appears at the outputs after edge N.
//    With an empty FIFO, trace_valid=1 in cycle N+1.
//  - Outputs are FWFT: trace_* always reflect the head entry.
//    Head is stable while trace_valid & !trace_ready.
//  - Sequence numbers:
//    - seq counter increments on every cap, including dropped commits.
//    - Each pushed entry stores the pre-increment value.
//    - A gap in trace_seq therefore identifies the drops; the counter wraps modulo 2^SEQ_W.
//  - Drop (cap & !push):
//    - drop_cnt += 1, saturating at 2^DROP_W-1.
//    - ovf_sticky <= 1.
//  - clr_ovf coinciding with a drop: the clear wins; drop_cnt=0, ovf_sticky=0.
//  - fifo_count: +1 on push only, -1 on pop only, unchanged on both or neither. Never exceeds DEPTH.
//  - Pointers are log2(DEPTH) bits and wrap naturally. Full/empty are derived from fifo_count.
//  - trace_en=0 does not stall the drain and does not clear contents.
//  - No combinational path from trace_ready to trace_valid or trace_* data.
// TESTING
//  T1 basic: reset, wen=1 addr=8 data=0x1234 pc=0x0040_0000 for one cycle, ready=1
//     -> next cycle valid=1, pc=0x00400000, addr=8, wdata=0x1234, seq=0; then valid=0.
//  T2 filter: wen=1 addr=0; then wen=0 addr=5; then trace_en=0 wen=1 addr=5
//     -> no entries, count=0, seq of next real capture = 0.
//  T3 fill/overflow: DEPTH=16, ready=0, 20 back-to-back captures
//     -> count=16, drop_cnt=4, ovf_sticky=1; drain yields seq 0..15.
//     Next capture stores seq=20.
//  T4 full+simultaneous: FIFO full, ready=1 and capture in same cycle
//     -> no drop, count stays 16, head advances seq 0->1.
//  T5 backpressure: 3 entries queued, ready toggles 1,0,0,1,1
//     -> entries popped in order, head held stable on ready=0 cycles.
//  T6 reset mid-stream / clear: 10 entries queued with drop_cnt=2, assert reset
//     -> valid=0, count=0, seq restarts at 0.
//     Separately, clr_ovf during a drop -> drop_cnt=0, ovf_sticky=0.

Source files
------------

// File: rtl/wb_trace_fifo.sv
`default_nettype none
// wb_trace_fifo: first-word-fall-through buffer of retired WB register writes, with sequence tags and drop accounting.
// Revision 1.0
module wb_trace_fifo #(
  parameter int DEPTH  = 16,
  parameter int SEQ_W  = 16,
  parameter int DROP_W = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       trace_en,
  input  logic                       clr_ovf,
  input  logic [31:0]                debug_wb_pc,
  input  logic                       debug_wb_rf_wen,
  input  logic [4:0]                 debug_wb_rf_addr,
  input  logic [31:0]                debug_wb_rf_wdata,
  output logic                       trace_valid,
  input  logic                       trace_ready,
  output logic [31:0]                trace_pc,
  output logic [4:0]                 trace_addr,
  output logic [31:0]                trace_wdata,
  output logic [SEQ_W-1:0]           trace_seq,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic                       ovf_sticky,
  output logic [DROP_W-1:0]          drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [31:0]      pc_mem   [DEPTH];
  logic [4:0]       addr_mem [DEPTH];
  logic [31:0]      data_mem [DEPTH];
  logic [SEQ_W-1:0] seq_mem  [DEPTH];

  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [SEQ_W-1:0] seq;

  logic cap;
  logic pop;
  logic push;
  logic drop;

  assign cap         = trace_en & debug_wb_rf_wen & (debug_wb_rf_addr != 5'd0);
  assign trace_valid = (count != '0);
  assign pop         = trace_valid & trace_ready;
  // A full FIFO still accepts a commit when the head leaves in the same cycle.
  assign push        = cap & ((count < DEPTH_C) | pop);
  assign drop        = cap & ~push;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      seq        <= '0;
      ovf_sticky <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // Dropped commits still consume a sequence number so consumers can spot gaps.
      if (cap) seq <= seq + 1'b1;
      if (clr_ovf) begin
        ovf_sticky <= 1'b0;
        drop_cnt   <= '0;
      end else if (drop) begin
        ovf_sticky <= 1'b1;
        if (drop_cnt != {DROP_W{1'b1}}) drop_cnt <= drop_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push) begin
      pc_mem[wr_ptr]   <= debug_wb_pc;
      addr_mem[wr_ptr] <= debug_wb_rf_addr;
      data_mem[wr_ptr] <= debug_wb_rf_wdata;
      seq_mem[wr_ptr]  <= seq;
    end
  end

  assign fifo_count  = count;
  assign trace_pc    = trace_valid ? pc_mem[rd_ptr]   : '0;
  assign trace_addr  = trace_valid ? addr_mem[rd_ptr] : '0;
  assign trace_wdata = trace_valid ? data_mem[rd_ptr] : '0;
  assign trace_seq   = trace_valid ? seq_mem[rd_ptr]  : '0;

endmodule
`default_nettype wire

// File: tb/tb_wb_trace_fifo.sv
`default_nettype none
// tb_wb_trace_fifo: directed and randomized checks of wb_trace_fifo against a queue-based reference model.
// Revision 1.0
module tb_wb_trace_fifo;

  localparam int DEPTH  = 16;
  localparam int SEQ_W  = 16;
  localparam int DROP_W = 16;
  localparam int CW     = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              reset;
  logic              trace_en;
  logic              clr_ovf;
  logic [31:0]       debug_wb_pc;
  logic              debug_wb_rf_wen;
  logic [4:0]        debug_wb_rf_addr;
  logic [31:0]       debug_wb_rf_wdata;
  logic              trace_valid;
  logic              trace_ready;
  logic [31:0]       trace_pc;
  logic [4:0]        trace_addr;
  logic [31:0]       trace_wdata;
  logic [SEQ_W-1:0]  trace_seq;
  logic [CW-1:0]     fifo_count;
  logic              ovf_sticky;
  logic [DROP_W-1:0] drop_cnt;

  wb_trace_fifo #(.DEPTH(DEPTH), .SEQ_W(SEQ_W), .DROP_W(DROP_W)) dut (
    .clk(clk), .reset(reset), .trace_en(trace_en), .clr_ovf(clr_ovf),
    .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
    .debug_wb_rf_addr(debug_wb_rf_addr), .debug_wb_rf_wdata(debug_wb_rf_wdata),
    .trace_valid(trace_valid), .trace_ready(trace_ready), .trace_pc(trace_pc),
    .trace_addr(trace_addr), .trace_wdata(trace_wdata), .trace_seq(trace_seq),
    .fifo_count(fifo_count), .ovf_sticky(ovf_sticky), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]      pc;
    logic [4:0]       addr;
    logic [31:0]      wdata;
    logic [SEQ_W-1:0] seq;
  } entry_t;

  entry_t            q[$];
  logic [SEQ_W-1:0]  m_seq;
  logic [DROP_W-1:0] m_drop;
  logic              m_ovf;
  int                n_tests = 0;
  int                n_fail  = 0;

  task automatic cmp(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: a queue of entries updated by the commit/drain rules, sampled just before the edge.
  task automatic model_step();
    bit     capm, popm, acc;
    entry_t e;
    if (reset) begin
      q.delete();
      m_seq  = '0;
      m_drop = '0;
      m_ovf  = 1'b0;
    end else begin
      capm = trace_en && debug_wb_rf_wen && (debug_wb_rf_addr != 5'd0);
      popm = (q.size() > 0) && trace_ready;
      acc  = capm && ((q.size() < DEPTH) || popm);
      if (popm) e = q.pop_front();
      if (acc) begin
        e.pc = debug_wb_pc; e.addr = debug_wb_rf_addr;
        e.wdata = debug_wb_rf_wdata; e.seq = m_seq;
        q.push_back(e);
      end
      if (capm) m_seq = m_seq + 1'b1;
      if (clr_ovf) begin
        m_drop = '0;
        m_ovf  = 1'b0;
      end else if (capm && !acc) begin
        m_ovf = 1'b1;
        if (m_drop != {DROP_W{1'b1}}) m_drop = m_drop + 1'b1;
      end
    end
  endtask

  task automatic check_model();
    entry_t h;
    h = '{pc: '0, addr: '0, wdata: '0, seq: '0};
    if (q.size() > 0) h = q[0];
    cmp("valid", 64'(trace_valid), 64'(q.size() > 0));
    cmp("count", 64'(fifo_count), 64'(q.size()));
    cmp("pc",    64'(trace_pc),    64'(h.pc));
    cmp("addr",  64'(trace_addr),  64'(h.addr));
    cmp("wdata", 64'(trace_wdata), 64'(h.wdata));
    cmp("seq",   64'(trace_seq),   64'(h.seq));
    cmp("ovf",   64'(ovf_sticky),  64'(m_ovf));
    cmp("drop",  64'(drop_cnt),    64'(m_drop));
  endtask

  task automatic cyc(input logic rst, input logic en, input logic wen, input logic [4:0] addr,
                     input logic [31:0] pc, input logic [31:0] data, input logic rdy,
                     input logic clr);
    reset = rst; trace_en = en; debug_wb_rf_wen = wen; debug_wb_rf_addr = addr;
    debug_wb_pc = pc; debug_wb_rf_wdata = data; trace_ready = rdy; clr_ovf = clr;
    model_step();
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic capture(input logic rdy, input int n);
    for (int i = 0; i < n; i++)
      cyc(0, 1, 1, 5'(1 + (i % 31)), 32'h1000 + 32'(i * 4), $urandom, rdy, 0);
  endtask

  initial begin
    q.delete(); m_seq = '0; m_drop = '0; m_ovf = 1'b0;
    // Reset state
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);

    // T1 basic
    cyc(0, 1, 1, 5'd8, 32'h0040_0000, 32'h1234, 1, 0);
    cmp("t1_valid", 64'(trace_valid), 64'd1);
    cmp("t1_pc",    64'(trace_pc),    64'h0040_0000);
    cmp("t1_addr",  64'(trace_addr),  64'd8);
    cmp("t1_wdata", 64'(trace_wdata), 64'h1234);
    cmp("t1_seq",   64'(trace_seq),   64'd0);
    cyc(0, 1, 0, 0, 0, 0, 1, 0);
    cmp("t1_empty", 64'(trace_valid), 64'd0);

    // T2 filter
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 1, 5'd0, 32'h10, 32'h11, 0, 0);
    cyc(0, 1, 0, 5'd5, 32'h14, 32'h22, 0, 0);
    cyc(0, 0, 1, 5'd5, 32'h18, 32'h33, 0, 0);
    cmp("t2_count", 64'(fifo_count), 64'd0);
    cyc(0, 1, 1, 5'd3, 32'h1c, 32'h44, 0, 0);
    cmp("t2_seq", 64'(trace_seq), 64'd0);

    // T3 fill/overflow
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    capture(0, 20);
    cmp("t3_count", 64'(fifo_count), 64'd16);
    cmp("t3_drop",  64'(drop_cnt),   64'd4);
    cmp("t3_ovf",   64'(ovf_sticky), 64'd1);
    for (int i = 0; i < 16; i++) begin
      cmp("t3_drain_seq", 64'(trace_seq), 64'(i));
      cyc(0, 1, 0, 0, 0, 0, 1, 0);
    end
    cmp("t3_empty", 64'(trace_valid), 64'd0);
    cyc(0, 1, 1, 5'd7, 32'h2000, 32'h77, 0, 0);
    cmp("t3_seq20", 64'(trace_seq), 64'd20);

    // T4 full + simultaneous pop/push
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    capture(0, 16);
    cyc(0, 1, 1, 5'd9, 32'h3000, 32'h99, 1, 0);
    cmp("t4_count", 64'(fifo_count), 64'd16);
    cmp("t4_drop",  64'(drop_cnt),   64'd0);
    cmp("t4_head",  64'(trace_seq),  64'd1);

    // T5 backpressure
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    capture(0, 3);
    cyc(0, 1, 0, 0, 0, 0, 1, 0);
    cmp("t5_h1", 64'(trace_seq), 64'd1);
    cyc(0, 1, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0, 0);
    cmp("t5_hold", 64'(trace_seq), 64'd1);
    cyc(0, 1, 0, 0, 0, 0, 1, 0);
    cmp("t5_h2", 64'(trace_seq), 64'd2);
    cyc(0, 1, 0, 0, 0, 0, 1, 0);
    cmp("t5_empty", 64'(trace_valid), 64'd0);

    // T6 reset mid-stream, then clear coinciding with a drop
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    capture(0, 18);
    for (int i = 0; i < 6; i++) cyc(0, 1, 0, 0, 0, 0, 1, 0);
    cmp("t6_count10", 64'(fifo_count), 64'd10);
    cmp("t6_drop2",   64'(drop_cnt),   64'd2);
    cyc(1, 1, 1, 5'd4, 32'h40, 32'h44, 1, 0);
    cmp("t6_rst_valid", 64'(trace_valid), 64'd0);
    cmp("t6_rst_count", 64'(fifo_count),  64'd0);
    cyc(0, 1, 1, 5'd4, 32'h40, 32'h44, 0, 0);
    cmp("t6_seq0", 64'(trace_seq), 64'd0);
    capture(0, 16);
    cyc(0, 1, 1, 5'd6, 32'h50, 32'h55, 0, 1);
    cmp("t6_clr_drop", 64'(drop_cnt),   64'd0);
    cmp("t6_clr_ovf",  64'(ovf_sticky), 64'd0);

    // Randomized traffic
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 149) == 0), ($urandom_range(0, 7) != 0),
          ($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)),
          $urandom, $urandom, ($urandom_range(0, 2) == 0),
          ($urandom_range(0, 39) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
